// File: rtl/grahzm8_alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// grahzm8_alu_arb_pkg
// Shared types and constants for the grahzm8 ALU arbiter slice.
//   arb_state_t : arbiter FSM state encoding (IDLE / EXEC / RESP)
//   DATA_W      : ALU datapath width (operands, instruction, result)
//   MAX_REQ     : largest supported requester count
// ---------------------------------------------------------------------------
package grahzm8_alu_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/grahzm8_alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// grahzm8_alu_arbiter_if
// Request/response bus between the requesters and the ALU arbiter.
//   req_valid/req_ready      : per-requester request handshake
//   req_a/req_b/req_instr    : flat operand/instruction buses, slice i = req i
//   rsp_valid/rsp_ready      : per-requester response handshake
//   rsp_data/rsp_id          : shared result and current owner index
//   req_lock                 : only when GRAHZM8_ALU_ARB_LOCK_EN is defined
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface grahzm8_alu_arbiter_if
  import grahzm8_alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*DATA_W-1:0] req_instr;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;

`ifdef GRAHZM8_ALU_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;

  modport master (
    output req_valid, req_a, req_b, req_instr, rsp_ready, req_lock,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_instr, rsp_ready, req_lock,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_instr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_instr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
`endif

endinterface

// File: rtl/grahzm8_rr_pick.sv
// ---------------------------------------------------------------------------
// grahzm8_rr_pick
// Combinational rotate-priority picker: the first set bit of i_valid at or
// above i_ptr (wrapping modulo N) wins.
//   i_valid : request vector
//   i_ptr   : highest-priority index, must be < N
//   o_grant : one-hot grant (zero when nothing is valid)
//   o_idx   : index of the winner (0 when nothing is valid)
//   o_any   : at least one request is valid
// ---------------------------------------------------------------------------
module grahzm8_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // w_src[k] is the requester index sitting k places after the pointer.
  logic [IDX_W-1:0] w_src [N];
  logic [N-1:0]     w_rot;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IDX_W:0] w_sum;
    // ptr < N and gi < N, so a single conditional subtract gives the modulo.
    assign w_sum     = {1'b0, i_ptr} + (IDX_W+1)'(gi);
    assign w_src[gi] = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                                 : IDX_W'(w_sum);
    assign w_rot[gi] = i_valid[w_src[gi]];
  end

  always_comb begin
    o_any   = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    // Scan from the far end so the position closest to the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        o_idx = w_src[k];
      end
    end
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/grahzm8_alu_arbiter.sv
// ---------------------------------------------------------------------------
// grahzm8_alu_arbiter
// Shares one combinational 8-bit ALU between NUM_REQ requesters using
// round-robin arbitration. Operands are registered on grant, the ALU is given
// one full cycle, the result is registered and held for the owner until its
// response handshake.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : request/response bus, see grahzm8_alu_arbiter_if
//   alu_in1/2      : registered operands to the ALU
//   alu_instr      : registered instruction byte to the ALU
//   alu_out        : ALU result
// Optional: GRAHZM8_ALU_ARB_LOCK_EN adds bus.req_lock; a locked owner keeps
// top priority for the next grant.
// ---------------------------------------------------------------------------
module grahzm8_alu_arbiter
  import grahzm8_alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  grahzm8_alu_arbiter_if.slave  bus,
  output logic [DATA_W-1:0]     alu_in1,
  output logic [DATA_W-1:0]     alu_in2,
  output logic [DATA_W-1:0]     alu_instr,
  input  logic [DATA_W-1:0]     alu_out
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_result;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_win_idx;
  logic               w_any;
  logic               w_rsp_hs;
  logic               w_keep;
  logic [ID_W-1:0]    w_ptr_next;

  logic [DATA_W-1:0] w_a     [NUM_REQ];
  logic [DATA_W-1:0] w_b     [NUM_REQ];
  logic [DATA_W-1:0] w_instr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a[gi]     = bus.req_a[gi*DATA_W +: DATA_W];
    assign w_b[gi]     = bus.req_b[gi*DATA_W +: DATA_W];
    assign w_instr[gi] = bus.req_instr[gi*DATA_W +: DATA_W];
  end

  grahzm8_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .i_valid (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_any   (w_any)
  );

  // Only the owner's rsp_ready line can complete a response.
  assign w_rsp_hs = (r_state == RESP) && bus.rsp_ready[r_owner];

`ifdef GRAHZM8_ALU_ARB_LOCK_EN
  assign w_keep = bus.req_lock[r_owner];
`else
  assign w_keep = 1'b0;
`endif

  assign w_ptr_next = w_keep ? r_owner :
                      (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = EXEC;
      EXEC:    w_state_next = RESP;
      RESP:    if (w_rsp_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    case (r_state)
      IDLE:    bus.req_ready = w_grant;
      RESP:    bus.rsp_valid[r_owner] = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_data = r_result;
  assign bus.rsp_id   = r_owner;

  // The ALU only ever sees registered values.
  assign alu_in1   = r_a;
  assign alu_in2   = r_b;
  assign alu_instr = r_instr;

  // Datapath and arbitration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_instr  <= '0;
      r_result <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_a     <= w_a[w_win_idx];
        r_b     <= w_b[w_win_idx];
        r_instr <= w_instr[w_win_idx];
        r_owner <= w_win_idx;
      end
      if (r_state == EXEC) begin
        r_result <= alu_out;
      end
      if (w_rsp_hs) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_grahzm8_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_grahzm8_alu_arbiter
// Directed testbench for grahzm8_alu_arbiter with a response scoreboard.
// A small behavioural ALU sits on the alu_* ports. Expected responses are
// pushed as stimulus is issued; a monitor pops and compares on each response
// handshake. Define GRAHZM8_ALU_ARB_LOCK_EN to also exercise req_lock.
// ---------------------------------------------------------------------------
module tb_grahzm8_alu_arbiter;
  import grahzm8_alu_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_MUL = 8'h05;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] alu_in1, alu_in2, alu_instr, alu_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rsp_count = 0;
  int remaining [NUM_REQ];

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_hist[$];

  grahzm8_alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  grahzm8_alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_instr (alu_instr),
    .alu_out   (alu_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU
  always_comb begin
    case (alu_instr)
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_SUB:  alu_out = alu_in1 - alu_in2;
      OP_AND:  alu_out = alu_in1 & alu_in2;
      OP_XOR:  alu_out = alu_in1 ^ alu_in2;
      OP_MUL:  alu_out = alu_in1 * alu_in2;
      default: alu_out = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input int n);
    bus.req_a[i*8 +: 8]     = a;
    bus.req_b[i*8 +: 8]     = b;
    bus.req_instr[i*8 +: 8] = op;
    remaining[i]            = n;
    bus.req_valid[i]        = 1'b1;
  endtask

  task automatic push(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_rsp(input int target, input string name);
    int n;
    n = 0;
    while (rsp_count < target && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(rsp_count >= target), 32'd1);
  endtask

  // Requester driver: drops a requester's valid (and lock) once its
  // requested number of grants has been taken.
  initial begin : driver
    logic [NUM_REQ-1:0] hs;
    forever begin
      @(negedge clk);
      hs = rst ? '0 : (bus.req_valid & bus.req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) begin
          remaining[i]--;
          if (remaining[i] <= 0) begin
            bus.req_valid[i] = 1'b0;
`ifdef GRAHZM8_ALU_ARB_LOCK_EN
            bus.req_lock[i] = 1'b0;
`endif
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    logic       in_resp;
    logic [7:0] held_data;
    int         held_id;
    int         acc;
    exp_t       e;
    in_resp = 1'b0;
    held_data = '0;
    held_id = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_q.delete();
        in_resp = 1'b0;
        continue;
      end
      if ((bus.req_valid & bus.req_ready) != '0) begin
        check("req_ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
        acc_q.push_back(cyc);
        acc_hist.push_back(cyc);
      end
      if (bus.rsp_valid != '0) begin
        check("no_grant_in_resp", 32'(bus.req_ready), 32'd0);
        if (!in_resp) begin
          in_resp   = 1'b1;
          held_data = bus.rsp_data;
          held_id   = int'(bus.rsp_id);
          if (acc_q.size() == 0) begin
            check("accept_before_rsp", 32'd0, 32'd1);
          end else begin
            acc = acc_q.pop_front();
            check("latency", 32'(cyc), 32'(acc + 2));
          end
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
          end
        end else begin
          check("hold_data", 32'(bus.rsp_data), 32'(held_data));
          check("hold_id", 32'(bus.rsp_id), 32'(held_id));
        end
        if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
          in_resp = 1'b0;
          rsp_count++;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            check("rsp_valid_onehot", 32'(bus.rsp_valid), 32'(1 << e.id));
            $display("rsp id=%0d data=%02h expect id=%0d data=%02h cycle=%0d",
                     bus.rsp_id, bus.rsp_data, e.id, e.data, cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    int base;
    int base_acc;
    int n;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_instr = '0;
    bus.rsp_ready = '0;
`ifdef GRAHZM8_ALU_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_alu_in1", 32'(alu_in1), 32'd0);
    check("reset_alu_in2", 32'(alu_in2), 32'd0);
    check("reset_alu_instr", 32'(alu_instr), 32'd0);

    // All four requesting continuously: grants 0,1,2,3,0, three cycles apart
    bus.rsp_ready = '1;
    base     = rsp_count;
    base_acc = acc_hist.size();
    issue(0, 8'hF0, 8'h20, OP_ADD, 2);
    issue(1, 8'h0F, 8'h11, OP_SUB, 1);
    issue(2, 8'h13, 8'h20, OP_MUL, 1);
    issue(3, 8'hAA, 8'h0F, OP_XOR, 1);
    push(0, 8'h10);
    push(1, 8'hFE);
    push(2, 8'h60);
    push(3, 8'hA5);
    push(0, 8'h10);
    wait_rsp(base + 5, "timeout_rr_all");
    check("rr_accept_count", 32'(acc_hist.size() >= base_acc + 5), 32'd1);
    if (acc_hist.size() >= base_acc + 5) begin
      for (int k = 1; k < 5; k++) begin
        check("rr_spacing", 32'(acc_hist[base_acc+k] - acc_hist[base_acc+k-1]), 32'd3);
      end
    end

    // Single request: 0x05 + 0x03
    base = rsp_count;
    issue(0, 8'h05, 8'h03, OP_ADD, 1);
    push(0, 8'h08);
    wait_rsp(base + 1, "timeout_single");

    // Response backpressure on req1; rsp_ready[2] high meanwhile
    base = rsp_count;
    bus.rsp_ready = 4'b1101;
    issue(1, 8'h3C, 8'h0F, OP_AND, 1);
    issue(2, 8'h7F, 8'h01, OP_ADD, 1);
    push(1, 8'h0C);
    push(2, 8'h80);
    n = 0;
    while (bus.rsp_valid[1] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("bp_rsp_seen", 32'(bus.rsp_valid), 32'b0010);
    repeat (5) tick();
    check("bp_no_handshake", 32'(rsp_count), 32'(base));
    check("bp_still_valid", 32'(bus.rsp_valid), 32'b0010);
    bus.rsp_ready = '1;
    wait_rsp(base + 2, "timeout_backpressure");

    // Pointer wrap: rr_ptr=3, req1 and req3 valid
    base = rsp_count;
    issue(1, 8'h01, 8'h02, OP_ADD, 1);
    issue(3, 8'h10, 8'h10, OP_SUB, 1);
    push(3, 8'h00);
    push(1, 8'h03);
    wait_rsp(base + 2, "timeout_wrap");

    // Move rr_ptr to 3, then reset mid-EXEC
    base = rsp_count;
    issue(2, 8'h09, 8'h09, OP_ADD, 1);
    push(2, 8'h12);
    wait_rsp(base + 1, "timeout_pre_reset");
    base = rsp_count;
    issue(0, 8'h44, 8'h44, OP_ADD, 1);
    tick();
    check("exec_operand_latched", 32'(alu_in1), 32'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_reset_alu_in1", 32'(alu_in1), 32'd0);
    repeat (4) tick();
    check("no_rsp_after_reset", 32'(rsp_count), 32'(base));
    check("rsp_valid_after_reset", 32'(bus.rsp_valid), 32'd0);
    issue(2, 8'h02, 8'h03, OP_MUL, 1);
    issue(3, 8'h80, 8'h80, OP_ADD, 1);
    push(2, 8'h06);
    push(3, 8'h00);
    wait_rsp(base + 2, "timeout_after_reset");

`ifdef GRAHZM8_ALU_ARB_LOCK_EN
    // Bring rr_ptr to 1, then req1 locked with req0/req2 competing
    base = rsp_count;
    issue(0, 8'h01, 8'h01, OP_ADD, 1);
    push(0, 8'h02);
    wait_rsp(base + 1, "timeout_pre_lock");
    base = rsp_count;
    bus.req_lock[1] = 1'b1;
    issue(1, 8'h11, 8'h22, OP_ADD, 2);
    issue(0, 8'h03, 8'h04, OP_ADD, 1);
    issue(2, 8'h05, 8'h06, OP_ADD, 1);
    push(1, 8'h33);
    push(1, 8'h33);
    push(2, 8'h0B);
    push(0, 8'h07);
    wait_rsp(base + 4, "timeout_lock");
`endif

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grahzm8_alu_arbiter.md
Name: grahzm8_alu_arbiter

Overview:
- Shares the single combinational 8-bit ALU (Input_1/Input_2/Instruction -> Output) between NUM_REQ requesters.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Registers the operands and instruction, drives the ALU from those registers, captures the ALU result and returns it to the granted requester.
- Sits between the CPU control/sequencing logic (and any DMA/address-gen users) and the ALU datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accepted, one-hot or zero.
- req_a  input  NUM_REQ*8  operand 1; slice i belongs to requester i.
- req_b  input  NUM_REQ*8  operand 2.
- req_instr  input  NUM_REQ*8  ALU instruction byte, passed unmodified to the ALU.
- rsp_valid  output  NUM_REQ  result valid, one-hot or zero.
- rsp_ready  input  NUM_REQ  per-requester result accept.
- rsp_data  output  8  result, shared by all requesters; meaningful only where rsp_valid is set.
- rsp_id  output  ID_W  index of the current owner.
- alu_in1  output  8  to ALU Input_1.
- alu_in2  output  8  to ALU Input_2.
- alu_instr  output  8  to ALU Instruction.
- alu_out  input  8  from ALU Output.

Behaviour:
- Reset state (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, owner=0.
  - a_q/b_q/instr_q/result_q=0.
  - All req_ready/rsp_valid=0; rsp_data=0; rsp_id=0; alu_in1/alu_in2/alu_instr=0.
- rst dominates everything. Reset mid-EXEC or mid-RESP drops the transaction silently; no rsp_valid follows.
- alu_in1/alu_in2/alu_instr always equal a_q/b_q/instr_q. They are never driven combinationally from requester inputs.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i], scanning from rr_ptr upward with wrap-around modulo NUM_REQ.
  - If a winner exists: req_ready[winner]=1 in the same cycle (combinational from req_valid and rr_ptr).
  - At that edge: latch that requester's a/b/instr into the operand registers, set owner=winner, go to EXEC.
  - If no request: stay in IDLE; req_ready=0.
  - Requesters must hold valid and payload stable until ready. A request may be withdrawn before grant.
- EXEC:
  - The ALU evaluates the registered operands for exactly one cycle.
  - At the edge: result_q<=alu_out, go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid[owner]=1, rsp_data=result_q, rsp_id=owner.
  - Hold until rsp_ready[owner]=1. rsp_ready on any other line is ignored.
  - On the handshake: rr_ptr<=(owner+1) mod NUM_REQ, go to IDLE.
  - req_ready=0 throughout RESP.
- Latency: request accepted at edge T; rsp_valid is high during cycle T+2.
  - Minimum 3 cycles per operation; the next grant is in the cycle after the response handshake.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 operations.
- Arithmetic: no width changes. Result is the ALU's 8-bit output; carries and upper multiply bits are not visible.
- req_ready and rsp_valid are never more than one bit set.

Optional Feature:
- Macro: GRAHZM8_ALU_ARB_LOCK_EN.
- With the macro defined:
  - Adds input req_lock[NUM_REQ].
  - If req_lock[owner]=1 during the RESP handshake, rr_ptr<=owner, so the owner keeps top priority for back-to-back sequences (e.g. multi-byte add chains).
  - Lock never preempts a transaction in flight.
  - A locked requester that does not assert req_valid in the next IDLE cycle loses priority normally to the next valid requester.
- Without the macro: no req_lock port; pure round-robin.

Decomposition:
- Package grahzm8_alu_arb_pkg holds:
  - the state enum (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the data width constant DATA_W=8;
  - the max requester count constant.
- Sub-module grahzm8_rr_pick: combinational rotate-priority picker.
  - Inputs: valid vector, pointer.
  - Outputs: one-hot grant, index, any_valid.
  - Reusable for the memory-port arbiter.

Test Plan:
- Single request: req0 a=0x05 b=0x03, instruction=add code; accept at T -> rsp_valid[0] at T+2, rsp_data=0x08, rsp_id=0.
- All four valid continuously, rsp_ready tied high -> grants 0,1,2,3,0 in order; each operation spaced 3 cycles apart.
- Response backpressure: hold rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_data held stable; no new req_ready until handshake. rsp_ready[2]=1 meanwhile is ignored.
- rr_ptr wrap: rr_ptr=3, only req1 and req3 valid -> req3 granted first, then req1.
- Reset mid-EXEC, then release -> no rsp_valid; next req2 is granted from rr_ptr=0 scan.
- LOCK_EN build: req1 with lock=1 and reqs 0/2 valid -> req1 granted twice consecutively; after lock drops, req2 is granted next.
